// File: rtl/door_timer.sv
`default_nettype none
// ============================================================================
//  Module   : door_timer
//  Purpose  : Elevator door sequencer. Runs the door through open, hold and
//             close phases, timed by the 1 Hz divider output sampled in the
//             system clock domain.
//  Options  : define DOOR_ALARM_EN to build the obstruction alarm counter;
//             without it, alarm is tied low.
//  Revision : 1.0 - initial release
// ============================================================================
module door_timer #(
  parameter int OPEN_SECONDS   = 10,
  parameter int MOTION_SECONDS = 2,
  parameter int CNT_W          = 4,
  parameter int OBSTRUCT_LIMIT = 30
) (
  input  logic             C_100Mhz,
  input  logic             Reset_n,
  input  logic             C_1Hz,
  input  logic             open_req,
  input  logic             close_req,
  input  logic             obstruct,
  output logic             motor_open,
  output logic             motor_close,
  output logic             door_open,
  output logic             door_closed,
  output logic [CNT_W-1:0] secs_left,
  output logic             alarm
);

  localparam logic [CNT_W-1:0] c_open_load   = CNT_W'(OPEN_SECONDS);
  localparam logic [CNT_W-1:0] c_motion_load = CNT_W'(MOTION_SECONDS);

  typedef enum logic [1:0] {
    ST_CLOSED  = 2'd0,
    ST_OPENING = 2'd1,
    ST_OPEN    = 2'd2,
    ST_CLOSING = 2'd3
  } state_t;

  state_t           r_state;
  state_t           w_state_next;
  logic [CNT_W-1:0] r_secs;
  logic [CNT_W-1:0] w_secs_next;
  logic [CNT_W-1:0] w_secs_dec;
  logic             w_wants_open;
  logic             w_expired;

  logic r_sync1;
  logic r_sync2;
  logic r_sync3;
  logic r_tick;

  // C_1Hz is asynchronous to C_100Mhz: two flops for metastability, a third
  // for edge detection, and a registered one-cycle tick.
  always_ff @(posedge C_100Mhz or negedge Reset_n) begin
    if (!Reset_n) begin
      r_sync1 <= 1'b0;
      r_sync2 <= 1'b0;
      r_sync3 <= 1'b0;
      r_tick  <= 1'b0;
    end else begin
      r_sync1 <= C_1Hz;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_tick  <= r_sync2 & ~r_sync3;
    end
  end

  assign w_wants_open = open_req | obstruct;
  assign w_expired    = (r_secs == '0);
  assign w_secs_dec   = (r_tick && !w_expired) ? (r_secs - CNT_W'(1)) : r_secs;

  always_ff @(posedge C_100Mhz or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_CLOSED;
      r_secs  <= '0;
    end else begin
      r_state <= w_state_next;
      r_secs  <= w_secs_next;
    end
  end

  // Any reload (entry or re-arm) overrides a coincident tick.
  always_comb begin
    w_state_next = r_state;
    w_secs_next  = w_secs_dec;
    case (r_state)
      ST_CLOSED: begin
        w_secs_next = '0;
        if (w_wants_open) begin
          w_state_next = ST_OPENING;
          w_secs_next  = c_motion_load;
        end
      end
      ST_OPENING: begin
        if (w_expired) begin
          w_state_next = ST_OPEN;
          w_secs_next  = c_open_load;
        end
      end
      ST_OPEN: begin
        if (w_wants_open) begin
          w_secs_next = c_open_load;
        end else if (w_expired || close_req) begin
          w_state_next = ST_CLOSING;
          w_secs_next  = c_motion_load;
        end
      end
      ST_CLOSING: begin
        if (w_wants_open) begin
          w_state_next = ST_OPENING;
          w_secs_next  = c_motion_load;
        end else if (w_expired) begin
          w_state_next = ST_CLOSED;
          w_secs_next  = '0;
        end
      end
      default: begin
        w_state_next = ST_CLOSED;
        w_secs_next  = '0;
      end
    endcase
  end

  assign door_closed = (r_state == ST_CLOSED);
  assign motor_open  = (r_state == ST_OPENING);
  assign door_open   = (r_state == ST_OPEN);
  assign motor_close = (r_state == ST_CLOSING);
  assign secs_left   = r_secs;

`ifdef DOOR_ALARM_EN
  localparam int c_obs_w = $clog2(OBSTRUCT_LIMIT + 1);
  localparam logic [c_obs_w-1:0] c_obs_limit = c_obs_w'(OBSTRUCT_LIMIT);

  logic [c_obs_w-1:0] r_obs_cnt;
  logic               r_alarm;
  logic               w_obs_zone;
  logic               w_at_limit;

  assign w_obs_zone = (r_state == ST_OPEN) || (r_state == ST_CLOSING);
  assign w_at_limit = (r_obs_cnt == c_obs_limit);

  // Alarm holds until the door reaches CLOSED, clearing on that same edge.
  always_ff @(posedge C_100Mhz or negedge Reset_n) begin
    if (!Reset_n) begin
      r_obs_cnt <= '0;
      r_alarm   <= 1'b0;
    end else if (w_state_next == ST_CLOSED) begin
      r_obs_cnt <= '0;
      r_alarm   <= 1'b0;
    end else begin
      if (w_at_limit) begin
        r_alarm <= 1'b1;
      end
      if (r_tick) begin
        if (!obstruct) begin
          r_obs_cnt <= '0;
        end else if (w_obs_zone && !w_at_limit) begin
          r_obs_cnt <= r_obs_cnt + c_obs_w'(1);
        end
      end
    end
  end

  assign alarm = r_alarm;
`else
  assign alarm = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_door_timer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_door_timer
//  Purpose  : Self-checking bench for door_timer: directed door scenarios plus
//             randomized requests against a phase/seconds reference model.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_door_timer;

  localparam int CNT_W   = 4;
  localparam int OPEN_S  = 10;
  localparam int MOVE_S  = 2;
  localparam int OBS_LIM = 5;

  localparam int SHUT = 0, RISING = 1, HELD = 2, FALLING = 3;

  logic             clk = 1'b0;
  logic             Reset_n;
  logic             C_1Hz = 1'b0;
  logic             open_req;
  logic             close_req;
  logic             obstruct;
  logic             motor_open;
  logic             motor_close;
  logic             door_open;
  logic             door_closed;
  logic [CNT_W-1:0] secs_left;
  logic             alarm;

  door_timer #(
    .OPEN_SECONDS  (OPEN_S),
    .MOTION_SECONDS(MOVE_S),
    .CNT_W         (CNT_W),
    .OBSTRUCT_LIMIT(OBS_LIM)
  ) dut (
    .C_100Mhz   (clk),
    .Reset_n    (Reset_n),
    .C_1Hz      (C_1Hz),
    .open_req   (open_req),
    .close_req  (close_req),
    .obstruct   (obstruct),
    .motor_open (motor_open),
    .motor_close(motor_close),
    .door_open  (door_open),
    .door_closed(door_closed),
    .secs_left  (secs_left),
    .alarm      (alarm)
  );

  always #5 clk = ~clk;
  // 200-cycle seconds base, edges kept away from the active clock edge
  always #1000 C_1Hz = ~C_1Hz;

  int vectors    = 0;
  int miscompares = 0;
  int cyc        = 0;

  // Reference model: door phase, seconds remaining, and history of C_1Hz
  // samples (bit 0 = newest) from which the seconds tick is derived.
  int       m_phase;
  int       m_left;
  bit [3:0] m_hist;
  int       m_obs;
  bit       m_alarm;
  int       dur [4] = '{0, MOVE_S, OPEN_S, MOVE_S};

  task automatic model_edge();
    bit tk;
    bit want;
    bit reload;
    int nxt;
    if (!Reset_n) begin
      m_phase = SHUT; m_left = 0; m_hist = '0; m_obs = 0; m_alarm = 1'b0;
      return;
    end
    // A C_1Hz rise becomes a tick acted on three samples later.
    tk     = m_hist[2] & ~m_hist[3];
    m_hist = {m_hist[2:0], C_1Hz};
    want   = open_req | obstruct;
`ifdef DOOR_ALARM_EN
    if (m_obs >= OBS_LIM) m_alarm = 1'b1;
    if (tk) begin
      if (!obstruct) m_obs = 0;
      else if ((m_phase == HELD || m_phase == FALLING) && m_obs < OBS_LIM) m_obs++;
    end
`endif
    nxt = m_phase;
    case (m_phase)
      SHUT:    if (want) nxt = RISING;
      RISING:  if (m_left == 0) nxt = HELD;
      HELD:    if (!want && (m_left == 0 || close_req)) nxt = FALLING;
      default: if (want) nxt = RISING; else if (m_left == 0) nxt = SHUT;
    endcase
    reload = (nxt != m_phase) || (m_phase == HELD && want);
    if (reload) m_left = dur[nxt];
    else if (tk && m_left > 0) m_left--;
    m_phase = nxt;
    if (m_phase == SHUT) begin m_obs = 0; m_alarm = 1'b0; end
  endtask

  task automatic compare_all();
    logic [8:0] got, exp;
    got = {motor_open, motor_close, door_open, door_closed, secs_left, alarm};
    exp = {m_phase == RISING, m_phase == FALLING, m_phase == HELD, m_phase == SHUT,
           CNT_W'(m_left), m_alarm};
    vectors++;
    if (got !== exp || (motor_open && motor_close)) begin
      miscompares++;
      $display("FAIL cycle %0d outputs {mo,mc,op,cl,secs,alarm}: got %b, expected %b",
               cyc, got, exp);
    end
  endtask

  task automatic run_cycle();
    @(posedge clk);
    model_edge();
    #1;
    cyc++;
    compare_all();
  endtask

  task automatic check(input string name, input int act, input int exp);
    vectors++;
    if (act != exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  int n;
  int obs_hold;

  initial begin
    Reset_n = 1'b0; open_req = 1'b0; close_req = 1'b0; obstruct = 1'b0;
    repeat (3) run_cycle();
    check("reset_door_closed", door_closed, 1);
    check("reset_secs_left", secs_left, 0);
    check("reset_motors", {motor_open, motor_close}, 0);
    check("reset_alarm", alarm, 0);
    Reset_n = 1'b1;
    repeat (5) run_cycle();

    // Full open/hold/close cycle from a one-cycle request
    open_req = 1'b1; run_cycle(); open_req = 1'b0;
    check("opening_motor", motor_open, 1);
    check("opening_secs", secs_left, 2);
    n = 0;
    while (!door_open && n < 500) begin run_cycle(); n++; end
    check("opening_len_in_range", int'(n >= 200 && n <= 402), 1);
    check("open_secs_loaded", secs_left, 10);

    // Obstruction re-arms the hold time
    for (int i = 0; i < 2400 && !(door_open && secs_left == 3); i++) run_cycle();
    obstruct = 1'b1; run_cycle(); obstruct = 1'b0;
    check("obstruct_reload_secs", secs_left, 10);
    check("obstruct_stays_open", door_open, 1);

    // close_req loses to obstruct, then wins alone
    for (int i = 0; i < 1000 && !(door_open && secs_left == 7); i++) run_cycle();
    close_req = 1'b1; obstruct = 1'b1; run_cycle(); obstruct = 1'b0;
    check("close_vs_obstruct_open", door_open, 1);
    check("close_vs_obstruct_secs", secs_left, 10);
    run_cycle(); close_req = 1'b0;
    check("early_close_motor", motor_close, 1);
    check("early_close_secs", secs_left, 2);

    // Reversal near the end of a close
    for (int i = 0; i < 600 && !(motor_close && secs_left == 1); i++) run_cycle();
    obstruct = 1'b1; run_cycle(); obstruct = 1'b0;
    check("reverse_motor_open", motor_open, 1);
    check("reverse_motor_close", motor_close, 0);
    check("reverse_secs", secs_left, 2);
    for (int i = 0; i < 3200 && !door_closed; i++) run_cycle();
    check("closed_after_cycle", door_closed, 1);
    check("closed_secs", secs_left, 0);

`ifdef DOOR_ALARM_EN
    open_req = 1'b1; run_cycle(); open_req = 1'b0;
    for (int i = 0; i < 500 && !door_open; i++) run_cycle();
    obstruct = 1'b1;
    for (int i = 0; i < 1600 && !alarm; i++) run_cycle();
    check("alarm_after_limit", alarm, 1);
    check("alarm_door_held", door_open, 1);
    obstruct = 1'b0;
    for (int i = 0; i < 3200 && !door_closed; i++) run_cycle();
    check("alarm_cleared_closed", alarm, 0);
`else
    check("alarm_tied_low", alarm, 0);
`endif

    // Asynchronous reset while the motor is opening
    open_req = 1'b1; run_cycle(); open_req = 1'b0;
    repeat (5) run_cycle();
    check("pre_reset_opening", motor_open, 1);
    Reset_n = 1'b0;
    #1;
    check("async_reset_motor_open", motor_open, 0);
    check("async_reset_door_closed", door_closed, 1);
    check("async_reset_secs", secs_left, 0);
    repeat (2) run_cycle();
    Reset_n = 1'b1;

    // Randomized requests with occasional sustained obstructions
    obs_hold = 0;
    for (int i = 0; i < 20000; i++) begin
      open_req  = ($urandom_range(0, 399) == 0);
      close_req = ($urandom_range(0, 149) == 0);
      if (obs_hold > 0) obs_hold--;
      else if ($urandom_range(0, 999) == 0) obs_hold = $urandom_range(1, 1200);
      obstruct = (obs_hold > 0);
      run_cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/door_timer.md
Name: door_timer

Overview:
- Elevator door sequencer.
- Sits directly downstream of the 100 MHz to 1 Hz frequency divider and consumes its C_1Hz square wave as a seconds time base.
- Runs the door through open, hold and close phases, with a hold time of OPEN_SECONDS (10 s by default, the system maximum).
- Drives the door motor commands and reports door status to the elevator controller FSM.

Parameters:
- OPEN_SECONDS, 10: seconds the door stays fully open before closing automatically. Legal range 1..2^CNT_W-1.
- MOTION_SECONDS, 2: seconds of motor travel for a full open or a full close. Legal range 1..2^CNT_W-1.
- CNT_W, 4: width of the seconds counter.
- OBSTRUCT_LIMIT, 30: seconds of continuous obstruction before the alarm asserts. Used only when DOOR_ALARM_EN is defined.

Ports:
- C_100Mhz  input  1  system clock, 100 MHz.
- Reset_n  input  1  asynchronous, active-low reset.
- C_1Hz  input  1  1 Hz square wave from the divider. Not a clock: it is sampled in the C_100Mhz domain.
- open_req  input  1  level request to open, from the controller or a cabin button.
- close_req  input  1  level request to close early.
- obstruct  input  1  door-edge sensor; 1 means something is blocking the door.
- motor_open  output  1  drive the motor in the open direction.
- motor_close  output  1  drive the motor in the close direction.
- door_open  output  1  door fully open.
- door_closed  output  1  door fully closed; the controller may move the car only while this is 1.
- secs_left  output  CNT_W  seconds remaining in the current timed phase.
- alarm  output  1  obstruction alarm.

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - state=CLOSED; all synchronizer flops = 0.
  - secs_left=0, door_closed=1, door_open=0, motor_open=0, motor_close=0, alarm=0.
- Tick generation:
  - C_1Hz passes through a 2-flop synchronizer, then a rising-edge detector.
  - tick is a single C_100Mhz-cycle pulse, once per second.
  - Latency from a C_1Hz rising edge to tick is 3 cycles.
  - Where the first tick falls inside a phase is unaligned, so each timed phase lasts N-1 to N seconds. This is accepted.
- States, all Moore outputs:
  - CLOSED: door_closed=1.
  - OPENING: motor_open=1.
  - OPEN: door_open=1.
  - CLOSING: motor_close=1.
- Counter rule:
  - On entry to a timed state, secs_left is loaded: OPENING and CLOSING load MOTION_SECONDS, OPEN loads OPEN_SECONDS.
  - Each tick decrements secs_left, saturating at 0.
  - A phase ends on the cycle after secs_left reaches 0.
  - In CLOSED, secs_left=0.
- Transitions:
  - CLOSED to OPENING: open_req=1 or obstruct=1.
  - OPENING to OPEN: motion count expired. open_req, close_req and obstruct are ignored while OPENING.
  - OPEN to CLOSING: hold count expired, or close_req=1, and in both cases obstruct=0.
  - OPEN, obstruct=1 or open_req=1: reload OPEN_SECONDS and stay in OPEN. This takes priority over close_req and over expiry.
  - CLOSING, obstruct=1 or open_req=1: go to OPENING and reload MOTION_SECONDS. The close is reversed.
  - CLOSING to CLOSED: motion count expired with no obstruct or open_req in that cycle.
- Simultaneous events:
  - A tick in the same cycle as a reload: the reload wins and no decrement is applied.
  - close_req in CLOSED or OPENING is ignored.
- motor_open and motor_close are never both 1. This is an invariant.
- Reset asserted mid-motion returns the block to CLOSED immediately. The door is then mechanically unknown; re-homing is the controller's responsibility.

Optional Feature:
- Macro: DOOR_ALARM_EN.
- When defined:
  - An obstruction counter increments on each tick while obstruct=1 in OPEN or CLOSING.
  - The counter clears when obstruct=0 is sampled on a tick.
  - When the count reaches OBSTRUCT_LIMIT, alarm=1.
  - alarm is sticky until state=CLOSED or reset.
- When undefined: alarm is tied to 0, and no counter logic is present.

Test Plan:
- Reset mid-OPENING (motor_open=1), assert Reset_n=0 -> on the same edge, motor_open=0, door_closed=1, secs_left=0.
- Bench period for C_1Hz = 200 cycles; pulse open_req for 1 cycle in CLOSED -> motor_open=1 for 2 ticks, then door_open=1 with secs_left=10, then after 10 ticks motor_close=1 for 2 ticks, then door_closed=1.
- In OPEN at secs_left=3, hold obstruct=1 for 1 cycle -> secs_left=10 on the next cycle, door_open stays 1.
- In CLOSING at secs_left=1, assert obstruct -> next cycle motor_open=1, motor_close=0, secs_left=2.
- In OPEN at secs_left=7, assert close_req=1 -> next cycle motor_close=1. With obstruct=1 in that same cycle, the door stays OPEN and reloads to 10.
- With DOOR_ALARM_EN and OBSTRUCT_LIMIT=5: hold obstruct in OPEN for 5 ticks -> alarm=1; release -> door closes and alarm clears on entry to CLOSED. Without the macro, alarm=0 throughout.
